// File: rtl/ula_seq_nbits.sv
`default_nettype none
// ============================================================================
//  Module   : ula_seq_nbits
//  Brief    : Parametrised sequential RPN ALU with start/busy/done handshake;
//             multi-cycle shift-add multiply and restoring divide.
//             Optional two's-complement mul/div and signed add/sub overflow
//             flag enabled by defining ULA_SIGNED_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module ula_seq_nbits #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ULA_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s_hi,
    output logic [WIDTH-1:0] resto,
    output logic [4:0]       flags
);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_mul = 3'b010;
    localparam logic [2:0] c_op_div = 3'b011;
    localparam logic [2:0] c_op_and = 3'b100;
    localparam logic [2:0] c_op_or  = 3'b101;
    localparam logic [2:0] c_op_xor = 3'b110;
    localparam logic [2:0] c_op_not = 3'b111;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Latched request
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_sel;
    logic             r_cin;
    logic             r_signed;
    logic             r_neg_q;
    logic             r_neg_r;

    // Iterative datapath: r_hi = partial product / partial remainder,
    // r_lo = multiplier being consumed / dividend shifting into quotient.
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sm_in;
`ifdef ULA_SIGNED_EN
    assign w_sm_in = signed_mode;
`else
    assign w_sm_in = 1'b0;
`endif

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_iter_op;

    assign w_a_neg   = w_sm_in & a[WIDTH-1];
    assign w_b_neg   = w_sm_in & b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -a : a;
    assign w_b_mag   = w_b_neg ? -b : b;
    assign w_iter_op = (sel == c_op_mul) || ((sel == c_op_div) && (b != '0));

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_tr;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_tr   = w_div_sh - {1'b0, r_opnd};
    assign w_prod_neg = -{r_hi, r_lo};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_iter_op ? EXEC : FIN;
                end
            end
            EXEC: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = r_signed ? FIX : FIN;
                end
            end
            FIX:     w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // ------------------------------------------------------------------
    // Result formation from latched operands / iterative datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_s_hi;
    logic [WIDTH-1:0] w_resto;
    logic             w_f_cy;
    logic             w_f_err;
    logic             w_f_rnz;
    logic             w_f_ovf;

    assign w_add = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};

    always_comb begin
        w_s     = '0;
        w_s_hi  = '0;
        w_resto = '0;
        w_f_cy  = 1'b0;
        w_f_err = 1'b0;
        w_f_rnz = 1'b0;
        w_f_ovf = 1'b0;
        case (r_sel)
            c_op_add: begin
                w_s    = w_add[WIDTH-1:0];
                w_f_cy = r_signed ? ((r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                     (w_add[WIDTH-1] != r_a[WIDTH-1]))
                                  : w_add[WIDTH];
            end
            c_op_sub: begin
                w_s    = w_sub[WIDTH-1:0];
                w_f_cy = r_signed ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                     (w_sub[WIDTH-1] != r_a[WIDTH-1]))
                                  : w_sub[WIDTH];
            end
            c_op_mul: begin
                w_s     = r_lo;
                w_s_hi  = r_hi;
                // Signed product fits only if the high half is pure sign extension
                w_f_ovf = r_signed ? (r_hi != {WIDTH{r_lo[WIDTH-1]}})
                                   : (r_hi != '0);
            end
            c_op_div: begin
                if (r_b == '0) begin
                    w_f_err = 1'b1;
                    w_resto = r_a;
                end else begin
                    w_s     = r_lo;
                    w_resto = r_hi;
                    w_f_rnz = (r_hi != '0);
                end
            end
            c_op_and: w_s = r_a & r_b;
            c_op_or:  w_s = r_a | r_b;
            c_op_xor: w_s = r_a ^ r_b;
            c_op_not: w_s = ~r_a;
            default:  w_s = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_cin    <= 1'b0;
            r_signed <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            done     <= 1'b0;
            s        <= '0;
            s_hi     <= '0;
            resto    <= '0;
            flags    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_sel    <= sel;
                        r_cin    <= cin;
                        r_signed <= w_sm_in;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_opnd   <= w_b_mag;
                        r_hi     <= '0;
                        r_lo     <= w_a_mag;
                        r_cnt    <= w_iter_op ? c_cnt_load : '0;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt - c_cnt_last;
                    if (r_sel == c_op_mul) begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end else if (!w_div_tr[WIDTH]) begin
                        r_hi <= w_div_tr[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_hi <= w_div_sh[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    // Re-apply signs to the magnitude results
                    if (r_sel == c_op_mul) begin
                        if (r_neg_q) begin
                            {r_hi, r_lo} <= w_prod_neg;
                        end
                    end else begin
                        if (r_neg_q) begin
                            r_lo <= -r_lo;
                        end
                        if (r_neg_r) begin
                            r_hi <= -r_hi;
                        end
                    end
                end
                FIN: begin
                    s     <= w_s;
                    s_hi  <= w_s_hi;
                    resto <= w_resto;
                    flags <= {w_f_ovf, (w_s == '0), w_f_rnz, w_f_err, w_f_cy};
                    done  <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ula_seq_nbits.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_seq_nbits
//  Brief    : Self-checking bench for ula_seq_nbits (WIDTH=8 and WIDTH=16),
//             directed steps plus randomized ops against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_seq_nbits;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8, cin8, busy8, done8;
    logic [2:0]  sel8;
    logic [7:0]  a8, b8, s8, shi8, resto8;
    logic [4:0]  flags8;

    logic        start16, cin16, busy16, done16;
    logic [2:0]  sel16;
    logic [15:0] a16, b16, s16, shi16, resto16;
    logic [4:0]  flags16;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ula_seq_nbits #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .s(s8), .s_hi(shi8),
        .resto(resto8), .flags(flags8)
    );

    ula_seq_nbits #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sel(sel16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .s(s16), .s_hi(shi16),
        .resto(resto16), .flags(flags16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on masked operands
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [63:0] x, input logic [63:0] y, input bit c,
                                  output logic [63:0] es, output logic [63:0] eh,
                                  output logic [63:0] er, output logic [4:0] ef);
        logic [63:0] mask;
        logic [63:0] t;
        mask = (64'd1 << w) - 64'd1;
        es = '0; eh = '0; er = '0; ef = '0;
        case (op)
            3'd0: begin t = x + y + 64'(c); es = t & mask; ef[0] = (t > mask); end
            3'd1: begin es = (x - y - 64'(c)) & mask; ef[0] = (x < y + 64'(c)); end
            3'd2: begin t = x * y; es = t & mask; eh = t >> w; ef[4] = (eh != 0); end
            3'd3: begin
                if (y == 0) begin ef[1] = 1'b1; er = x; end
                else begin es = x / y; er = x % y; ef[2] = (er != 0); end
            end
            3'd4: es = x & y;
            3'd5: es = x | y;
            3'd6: es = x ^ y;
            default: es = ~x & mask;
        endcase
        ef[3] = (es == 0);
    endfunction

    task automatic drive(input int w, input bit st, input logic [2:0] op,
                         input logic [63:0] x, input logic [63:0] y, input bit c);
        if (w == 16) begin
            start16 = st; sel16 = op; a16 = x[15:0]; b16 = y[15:0]; cin16 = c;
        end else begin
            start8 = st; sel8 = op; a8 = x[7:0]; b8 = y[7:0]; cin8 = c;
        end
    endtask

    task automatic sample(input int w, output logic dn, output logic bz,
                          output logic [63:0] os, output logic [63:0] oh,
                          output logic [63:0] orr, output logic [4:0] ofl);
        if (w == 16) begin
            dn = done16; bz = busy16; os = 64'(s16); oh = 64'(shi16);
            orr = 64'(resto16); ofl = flags16;
        end else begin
            dn = done8; bz = busy8; os = 64'(s8); oh = 64'(shi8);
            orr = 64'(resto8); ofl = flags8;
        end
    endtask

    // One transaction: start at a negedge, scramble inputs after acceptance,
    // wait (bounded) for done, then compare latency and all results.
    task automatic do_op(input string nm, input int w, input logic [2:0] op,
                         input logic [63:0] x, input logic [63:0] y, input bit c,
                         input bit poke);
        logic [63:0] es, eh, er, os, oh, orr;
        logic [4:0]  ef, ofl;
        logic        dn, bz;
        int          exp_lat, lat;
        model(w, op, x, y, c, es, eh, er, ef);
        exp_lat = ((op == 3'd2) || (op == 3'd3 && y != 0)) ? w + 1 : 1;
        @(negedge clk);
        drive(w, 1'b1, op, x, y, c);
        @(posedge clk); #1;
        drive(w, 1'b0, 3'($urandom), 64'($urandom), 64'($urandom), 1'($urandom));
        sample(w, dn, bz, os, oh, orr, ofl);
        check({nm, ".busy_on"}, 64'(bz), 64'd1);
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            if (poke && k == 3) drive(w, 1'b1, 3'd0, 64'd1, 64'd1, 1'b0);
            if (poke && k == 4) drive(w, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
            @(posedge clk); #1;
            sample(w, dn, bz, os, oh, orr, ofl);
            if (dn) lat = k;
        end
        check({nm, ".latency"}, 64'(lat), 64'(exp_lat));
        check({nm, ".busy_off"}, 64'(bz), 64'd0);
        check({nm, ".s"}, os, es);
        check({nm, ".s_hi"}, oh, eh);
        check({nm, ".resto"}, orr, er);
        check({nm, ".flags"}, 64'(ofl), 64'(ef));
    endtask

    initial begin
        logic [63:0] os, oh, orr;
        logic [4:0]  ofl;
        logic        dn, bz;
        int          seen;

        rst_n = 1'b0;
        drive(8, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        drive(16, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        sample(8, dn, bz, os, oh, orr, ofl);
        check("reset.busy", 64'(bz), 64'd0);
        check("reset.done", 64'(dn), 64'd0);
        check("reset.outs", {os[7:0], oh[7:0], orr[7:0], 3'd0, ofl}, 64'd0);
        rst_n = 1'b1;

        do_op("add200_100", 8, 3'd0, 64'd200, 64'd100, 1'b0, 1'b0);
        check("add.value", 64'(s8), 64'd44);
        do_op("sub5_7", 8, 3'd1, 64'd5, 64'd7, 1'b0, 1'b0);
        check("sub.value", 64'(s8), 64'd254);
        do_op("andF0_0F", 8, 3'd4, 64'hF0, 64'h0F, 1'b0, 1'b0);
        check("and.zero", 64'(flags8[3]), 64'd1);
        do_op("mul20_15", 8, 3'd2, 64'd20, 64'd15, 1'b0, 1'b1);
        check("mul.value", {s_hi_val(), 56'd0} | 64'(s8), {8'h01, 56'd0} | 64'h2C);

        // Outputs hold after the done pulse
        @(posedge clk); #1;
        check("hold.done", 64'(done8), 64'd0);
        check("hold.s", 64'(s8), 64'h2C);

        do_op("div100_7", 8, 3'd3, 64'd100, 64'd7, 1'b0, 1'b0);
        do_op("div100_0", 8, 3'd3, 64'd100, 64'd0, 1'b0, 1'b0);
        do_op("sub_cin", 8, 3'd1, 64'd7, 64'd7, 1'b1, 1'b0);
        do_op("add_cin", 8, 3'd0, 64'd255, 64'd0, 1'b1, 1'b0);
        do_op("not", 8, 3'd7, 64'hA5, 64'hFF, 1'b0, 1'b0);
        do_op("div255_1", 8, 3'd3, 64'd255, 64'd1, 1'b0, 1'b0);
        do_op("mul255_255", 8, 3'd2, 64'd255, 64'd255, 1'b0, 1'b0);

        // Reset while a divide is in flight
        @(negedge clk);
        drive(8, 1'b1, 3'd3, 64'd200, 64'd3, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sample(8, dn, bz, os, oh, orr, ofl);
        check("abort.busy", 64'(bz), 64'd0);
        check("abort.done", 64'(dn), 64'd0);
        check("abort.outs", {os[7:0], orr[7:0], 3'd0, ofl}, 64'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        check("abort.no_done", 64'(seen), 64'd0);
        do_op("div9_3", 8, 3'd3, 64'd9, 64'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] ry;
            ry = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            do_op("rand8", 8, 3'($urandom_range(0, 7)), 64'($urandom_range(0, 255)),
                  ry, 1'($urandom_range(0, 1)), 1'b0);
        end

        do_op("mul300_300", 16, 3'd2, 64'd300, 64'd300, 1'b0, 1'b0);
        check("mul16.value", {32'(shi16), 32'(s16)}, {32'h0001, 32'h5F90});
        for (int i = 0; i < 10; i++) begin
            do_op("rand16", 16, 3'($urandom_range(0, 7)), 64'($urandom_range(0, 65535)),
                  64'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    function automatic logic [7:0] s_hi_val();
        return shi8;
    endfunction

endmodule
`default_nettype wire

// File: doc/ula_seq_nbits.md
Name: ula_seq_nbits

Overview:
- Parametrised, clocked successor to the 8-bit combinational RPN ALU.
- Operand width is generic. Operands and results are registered.
- Multiplication (shift-add) and division (restoring) are done internally over multiple cycles, so the RPN controller no longer computes them.
- Sits between the RPN stack/controller and the display/flag logic. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (min 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- sel  in  3  operation: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 not A.
- a  in  WIDTH  operand A (dividend).
- b  in  WIDTH  operand B (divisor); ignored for not.
- cin  in  1  carry-in for add, borrow-in for sub.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are valid.
- s  out  WIDTH  result (low half of the product for mul, quotient for div).
- s_hi  out  WIDTH  high half of the product for mul; 0 for all other ops.
- resto  out  WIDTH  remainder for div; 0 for all other ops.
- flags  out  5  [0] cout/bout, [1] erro, [2] resto nonzero, [3] zero, [4] mul overflow.

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM to IDLE; busy, done, s, s_hi, resto, flags all 0; counter 0.
- FSM states: IDLE, EXEC, FIN.
- IDLE:
  - On start=1, latch a, b, sel, cin.
  - Ops 000, 001, 1xx, and div with b=0: go to FIN.
  - mul/div with b!=0: load datapath, counter=WIDTH, go to EXEC.
- EXEC: one shift-add (mul) or one restore step (div) per cycle; counter decrements; at counter==1 go to FIN.
- FIN: write outputs and flags, pulse done=1 for one cycle, return to IDLE.
- busy is 1 in EXEC and FIN.
- Latency (start sampled at edge t):
  - Single-cycle ops: done high in cycle t+1.
  - mul/div: done high in cycle t+WIDTH+1.
  - A new start may be sampled in the same cycle done is high (IDLE re-entered after FIN).
- start while busy=1: ignored; latched operands are unchanged.
- Input changes after acceptance: no effect on the result.
- Outputs hold their values until the next FIN or reset.
- Add: {cout,s} = a+b+cin.
- Sub: s = a-b-cin mod 2^WIDTH; bout=1 iff a < b+cin.
- flags[0] is 0 for all ops other than add/sub.
- Mul: {s_hi,s} = a*b, unsigned; flags[4] = (s_hi != 0).
- Div, b!=0: s = a/b, resto = a%b, flags[2] = (resto != 0).
- Div, b=0: erro flag set, s=0, resto=a, flags[2]=0, single-cycle.
- flags[3] = (s == 0), evaluated on the final s for every op.
- Logic ops: bitwise on WIDTH bits; not ignores b.
- Reset mid-EXEC: operation aborted, no done pulse, all outputs cleared.

Optional Feature:
- Macro ULA_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), latched at start.
  - When signed_mode=1, mul/div use two's-complement operands: magnitudes are computed, the unsigned core runs, then results are sign-corrected in one extra FIN-preceding cycle.
  - mul/div latency becomes t+WIDTH+2.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - flags[4] for signed mul = product does not fit in signed WIDTH bits.
  - For add/sub, flags[0] reports signed overflow instead of carry.
  - Div by zero is unchanged.
- Not defined: port absent, unsigned-only behaviour exactly as above.

Test Plan:
- WIDTH=8, add a=200 b=100 cin=0 -> s=44, flags[0]=1, flags[3]=0, done at t+1.
- WIDTH=8, sub a=5 b=7 cin=0 -> s=254, flags[0]=1. Then and a=0xF0 b=0x0F -> s=0, flags[3]=1.
- WIDTH=8, mul a=20 b=15 -> s=0x2C, s_hi=0x01, flags[4]=1, busy for 8+1 cycles, done exactly at t+9. Assert start mid-op with other operands -> ignored, result unchanged.
- WIDTH=8, div a=100 b=7 -> s=14, resto=2, flags[2]=1, done t+9. Then div a=100 b=0 -> flags[1]=1, s=0, resto=100, done t+1.
- WIDTH=8, div a=200 b=3 with rst_n=0 at t+4 -> no done pulse, busy=0, s/resto/flags=0 next cycle. Next start a=9 b=3 -> s=3, resto=0.
- WIDTH=16, mul a=300 b=300 -> s=0x5F90, s_hi=0x0001, done t+17. With ULA_SIGNED_EN, WIDTH=8, signed div a=0xF9 (-7) b=2 -> s=0xFD, resto=0xFF, done t+10.
